// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI command arbiter: state encoding,
// default watchdog limit and the grant-index width helper.
package spi_arb_pkg;

    localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
    localparam logic [2:0] ST_SETUP_ENC     = 3'd1;
    localparam logic [2:0] ST_LAUNCH_ENC    = 3'd2;
    localparam logic [2:0] ST_WAIT_LOW_ENC  = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = ST_IDLE_ENC,
        ST_SETUP     = ST_SETUP_ENC,
        ST_LAUNCH    = ST_LAUNCH_ENC,
        ST_WAIT_LOW  = ST_WAIT_LOW_ENC,
        ST_WAIT_HIGH = ST_WAIT_HIGH_ENC
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT = 32'sd4096;
    localparam int WDOG_W          = 32'sd16;

    // Width of an index able to address n requesters (never below one bit).
    function automatic int idx_width(input int n);
        if (n <= 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: returns the first asserted request at or after
// ptr, wrapping modulo R. Purely combinational; the pointer lives in the parent.
module rr_pick
    import spi_arb_pkg::*;
#(
    parameter int R  = 4,
    parameter int IW = 2
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gid,
    output logic          any
);

    logic [2*R-1:0] dbl_s;
    logic [R-1:0]   rot_s;
    logic [IW-1:0]  off_s;
    logic [IW:0]    sum_s;

    // Rotate the request vector so ptr lands at bit 0, find the lowest set
    // bit, then map that offset back to an absolute requester index.
    always_comb begin
        dbl_s = {req, req} >> ptr;
        rot_s = dbl_s[R-1:0];
        off_s = '0;
        any   = 1'b0;
        for (int k = R - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? IW'(k) : off_s;
            any   = rot_s[k] | any;
        end
        sum_s = {1'b0, ptr} + {1'b0, off_s};
        if (sum_s >= (IW + 1)'(R)) begin
            sum_s = sum_s - (IW + 1)'(R);
        end else begin
            sum_s = sum_s;
        end
        gid = sum_s[IW-1:0];
    end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_master among R requesters.
// Grants a command, presents it to the master, triggers a frame, waits for
// completion (or watchdog expiry) and pulses done back to the winner.
module spi_cmd_arbiter
    import spi_arb_pkg::*;
#(
    parameter int R       = 4,
    parameter int N       = 10,
    parameter int C       = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic           CLK_IN,
    input  logic           RST_N,
    input  logic [R-1:0]   req,
    input  logic [R*C-1:0] req_din,
    input  logic [R*N-1:0] req_target,
    input  logic [R-1:0]   req_cpol,
    input  logic [R-1:0]   req_cpha,
    output logic [R-1:0]   ack,
    output logic [R-1:0]   done,
    output logic           err,
    output logic [C-1:0]   rdata,
    output logic           busy,
    output logic [C-1:0]   din,
    output logic [N-1:0]   target,
    output logic           CPOL,
    output logic           CPHA,
    output logic           trigger,
    input  logic [C-1:0]   dout,
    input  logic           valid
);

    localparam int                IW  = idx_width(R);
    localparam int                WW  = WDOG_W;
    localparam logic [WW-1:0]     TMO = WW'(TIMEOUT);

    arb_state_e    state_r, state_nx_s;
    logic [IW-1:0] ptr_r, gid_r, pick_s, ptr_nx_s;
    logic          any_s;
    logic          grant_s, complete_s, timeout_s, wdog_run_s, wdog_hit_s;
    logic [WW-1:0] wdog_r;
    logic [C-1:0]  sel_din_s;
    logic [N-1:0]  sel_target_s;
    logic          sel_cpol_s, sel_cpha_s;
    logic [R-1:0]  pick_hot_s, gid_hot_s;

    logic [R-1:0]  ack_r, done_r;
    logic          err_r, busy_r, trigger_r, cpol_r, cpha_r;
    logic [C-1:0]  rdata_r, din_r;
    logic [N-1:0]  target_r;

    rr_pick #(.R(R), .IW(IW)) u_pick (
        .req (req),
        .ptr (ptr_r),
        .gid (pick_s),
        .any (any_s)
    );

    // Payload mux for the current pick and one-hot forms of pick and grant.
    always_comb begin
        sel_din_s    = '0;
        sel_target_s = '0;
        sel_cpol_s   = 1'b0;
        sel_cpha_s   = 1'b0;
        pick_hot_s   = '0;
        gid_hot_s    = '0;
        for (int i = 0; i < R; i++) begin
            if (pick_s == IW'(i)) begin
                sel_din_s     = req_din[i*C +: C];
                sel_target_s  = req_target[i*N +: N];
                sel_cpol_s    = req_cpol[i];
                sel_cpha_s    = req_cpha[i];
                pick_hot_s[i] = 1'b1;
            end else begin
                pick_hot_s[i] = 1'b0;
            end
            gid_hot_s[i] = (gid_r == IW'(i));
        end
        ptr_nx_s   = (pick_s == IW'(R - 1)) ? '0 : pick_s + IW'(1);
        wdog_hit_s = ((wdog_r + WW'(1)) == TMO);
    end

    // Next-state and control strobes; completion has priority over watchdog.
    always_comb begin
        state_nx_s = state_r;
        grant_s    = 1'b0;
        complete_s = 1'b0;
        timeout_s  = 1'b0;
        wdog_run_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (valid && any_s) begin
                    grant_s    = 1'b1;
                    state_nx_s = ST_SETUP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETUP:  state_nx_s = ST_LAUNCH;
            ST_LAUNCH: state_nx_s = ST_WAIT_LOW;
            ST_WAIT_LOW: begin
                wdog_run_s = 1'b1;
                if (wdog_hit_s) begin
                    timeout_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else if (!valid) begin
                    state_nx_s = ST_WAIT_HIGH;
                end else begin
                    state_nx_s = ST_WAIT_LOW;
                end
            end
            ST_WAIT_HIGH: begin
                wdog_run_s = 1'b1;
                if (valid) begin
                    complete_s = 1'b1;
                    state_nx_s = ST_IDLE;
                end else if (wdog_hit_s) begin
                    timeout_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_HIGH;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Grant capture, pointer rotation, watchdog and registered output pulses.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            ptr_r     <= '0;
            gid_r     <= '0;
            wdog_r    <= '0;
            ack_r     <= '0;
            done_r    <= '0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            trigger_r <= 1'b0;
            rdata_r   <= '0;
            din_r     <= '0;
            target_r  <= '0;
            cpol_r    <= 1'b0;
            cpha_r    <= 1'b0;
        end else begin
            ack_r     <= grant_s ? pick_hot_s : '0;
            done_r    <= (complete_s || timeout_s) ? gid_hot_s : '0;
            err_r     <= timeout_s;
            busy_r    <= (state_nx_s != ST_IDLE);
            trigger_r <= (state_nx_s == ST_LAUNCH);
            if (grant_s) begin
                din_r    <= sel_din_s;
                target_r <= sel_target_s;
                cpol_r   <= sel_cpol_s;
                cpha_r   <= sel_cpha_s;
                gid_r    <= pick_s;
                ptr_r    <= ptr_nx_s;
            end else begin
                din_r    <= din_r;
                target_r <= target_r;
                cpol_r   <= cpol_r;
                cpha_r   <= cpha_r;
                gid_r    <= gid_r;
                ptr_r    <= ptr_r;
            end
            if (complete_s) begin
                rdata_r <= dout;
            end else begin
                rdata_r <= rdata_r;
            end
            if (state_r == ST_LAUNCH) begin
                wdog_r <= '0;
            end else if (wdog_run_s) begin
                wdog_r <= wdog_r + WW'(1);
            end else begin
                wdog_r <= wdog_r;
            end
        end
    end

    assign ack     = ack_r;
    assign done    = done_r;
    assign err     = err_r;
    assign busy    = busy_r;
    assign trigger = trigger_r;
    assign rdata   = rdata_r;
    assign din     = din_r;
    assign target  = target_r;
    assign CPOL    = cpol_r;
    assign CPHA    = cpha_r;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Self-checking bench for spi_cmd_arbiter: a behavioural SPI master, a
// transaction-level round-robin reference model and randomized traffic.
module tb_spi_cmd_arbiter;

    localparam int R   = 4;
    localparam int N   = 10;
    localparam int C   = 16;
    localparam int TMO = 100;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [R-1:0]   req;
    logic [R*C-1:0] req_din;
    logic [R*N-1:0] req_target;
    logic [R-1:0]   req_cpol, req_cpha;
    logic [R-1:0]   ack, done;
    logic           err, busy, cpol, cpha, trigger;
    logic [C-1:0]   rdata, din;
    logic [N-1:0]   target;
    logic [C-1:0]   dout  = 16'h0000;
    logic           valid = 1'b1;

    spi_cmd_arbiter #(.R(R), .N(N), .C(C), .TIMEOUT(TMO)) dut (
        .CLK_IN(clk), .RST_N(rst_n), .req(req), .req_din(req_din),
        .req_target(req_target), .req_cpol(req_cpol), .req_cpha(req_cpha),
        .ack(ack), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .din(din), .target(target), .CPOL(cpol), .CPHA(cpha),
        .trigger(trigger), .dout(dout), .valid(valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural master: valid drops one cycle after trigger, returns after m_lat cycles.
    int m_phase = 0;
    int m_cnt   = 0;
    int m_lat   = 40;
    bit m_hang  = 1'b0;
    bit m_release = 1'b0;

    always @(negedge clk) begin
        if (m_release) begin
            valid = 1'b1;
            m_phase = 0;
            m_release = 1'b0;
        end else if (m_phase == 0) begin
            if (trigger) m_phase = 1;
        end else if (m_phase == 1) begin
            valid = 1'b0;
            m_cnt = 0;
            m_phase = 2;
        end else begin
            m_cnt++;
            if (!m_hang && m_cnt >= m_lat) begin
                dout = din ^ 16'hFFFF;
                valid = 1'b1;
                m_phase = 0;
            end
        end
    end

    // Pulse exclusivity / one-hot monitor.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check_val("ack_done_excl", ((ack != '0) && (done != '0)) ? 32'd1 : 32'd0, 32'd0);
            check_val("pulse_onehot", ($onehot0(ack) && $onehot0(done)) ? 32'd1 : 32'd0, 32'd1);
        end
    end

    // Reference model state.
    logic [C-1:0] p_din[R];
    logic [N-1:0] p_tgt[R];
    logic         p_cpol[R];
    logic         p_cpha[R];
    int           ptr_m   = 0;
    logic [C-1:0] rdata_m = 16'h0000;

    function automatic int predict(input logic [R-1:0] p, input int from);
        for (int k = 0; k < R; k++) begin
            int idx;
            idx = (from + k) % R;
            if (p[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [C-1:0] d, input logic [N-1:0] t,
                           input logic pol, input logic pha);
        p_din[i] = d; p_tgt[i] = t; p_cpol[i] = pol; p_cpha[i] = pha;
        req_din[i*C +: C]    = d;
        req_target[i*N +: N] = t;
        req_cpol[i] = pol;
        req_cpha[i] = pha;
        req[i] = 1'b1;
    endtask

    task automatic set_rand(input int i);
        set_req(i, 16'($urandom), 10'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // One full transaction against the model; returns the granted index.
    task automatic serve_one(input logic [R-1:0] keep, input int lat, input bit hang,
                             input int pulse_idx, input bit chk_lat, output int w);
        int cyc;
        w = predict(req, ptr_m);
        m_lat = lat;
        m_hang = hang;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (ack == '0 && cyc < 300);
        if (chk_lat) check_val("ack_latency", cyc, 1);
        check_val("ack_idx", ack, 32'd1 << w);
        check_val("busy_in_setup", busy, 1);
        check_val("bus_din", din, p_din[w]);
        check_val("bus_target", target, p_tgt[w]);
        check_val("bus_mode_setup", {cpol, cpha}, {p_cpol[w], p_cpha[w]});
        ptr_m = (w + 1) % R;
        if (!keep[w]) req[w] = 1'b0;
        @(negedge clk);
        check_val("trigger", trigger, 1);
        check_val("ack_one_cycle", ack, 0);
        check_val("bus_mode_launch", {cpol, cpha}, {p_cpol[w], p_cpha[w]});
        cyc = 0;
        if (pulse_idx >= 0) begin
            req[pulse_idx] = 1'b1;
            @(negedge clk);
            req[pulse_idx] = 1'b0;
            cyc = 1;
        end
        while (done == '0 && cyc < TMO + 50) begin @(negedge clk); cyc++; end
        check_val("done_idx", done, 32'd1 << w);
        check_val("done_latency", cyc, hang ? TMO + 1 : lat + 2);
        check_val("err", err, hang);
        if (!hang) rdata_m = p_din[w] ^ 16'hFFFF;
        check_val("rdata", rdata, rdata_m);
        check_val("busy_done", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pulses"}, {ack, done, err, busy, trigger}, 0);
        check_val({tag, "_rdata"}, rdata, 0);
        check_val({tag, "_bus"}, {din, target, cpol, cpha}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int w, prev, cyc;
        logic [R-1:0] mask;
        rst_n = 1'b0; req = '0; req_din = '0; req_target = '0; req_cpol = '0; req_cpha = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single request
        set_req(2, 16'hA55A, 10'h004, 1'b0, 1'b0);
        serve_one('0, 40, 1'b0, -1, 1'b1, w);
        check_val("single_gid", w, 2);
        check_val("single_rdata", rdata, 16'h5AA5);

        // All requesters at once after reset
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; ptr_m = 0; rdata_m = 16'h0000;
        @(negedge clk);
        for (int i = 0; i < R; i++) set_req(i, 16'($urandom), 10'($urandom), 1'(i & 1), 1'(i >> 1));
        for (int i = 0; i < R; i++) begin
            serve_one('0, 40, 1'b0, -1, 1'b1, w);
            check_val("all_order", w, i);
        end

        // Fairness: req[1] and req[3] held continuously
        set_rand(1); set_rand(3);
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            serve_one(4'b1010, $urandom_range(1, 60), 1'b0, -1, 1'b1, w);
            check_val("fair_alternate", (w != prev) ? 32'd1 : 32'd0, 32'd1);
            prev = w;
        end
        req = '0;

        // Randomized traffic
        for (int r = 0; r < 8; r++) begin
            mask = 4'($urandom_range(1, (1 << R) - 1));
            for (int i = 0; i < R; i++) if (mask[i]) set_rand(i);
            while (req != '0) serve_one('0, $urandom_range(1, 60), 1'b0, -1, 1'b1, w);
        end

        // Withdrawal: one-cycle req pulse while busy is never granted
        set_rand(0);
        serve_one('0, 30, 1'b0, 1, 1'b1, w);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("withdrawn_no_ack", ack, 0);
        end

        // valid rises on the same edge the watchdog limit is reached
        set_rand(3);
        serve_one('0, TMO - 1, 1'b0, -1, 1'b1, w);

        // Watchdog expiry, then no grant until valid returns
        set_rand(1);
        serve_one('0, 40, 1'b1, -1, 1'b1, w);
        set_rand(2);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check_val("wdog_hold_off", {ack, trigger}, 0);
        end
        m_hang = 1'b0; m_release = 1'b1;
        serve_one('0, 40, 1'b0, -1, 1'b0, w);
        check_val("wdog_next_gid", w, 2);

        // Reset during WAIT_HIGH
        set_rand(3);
        m_hang = 1'b1;
        cyc = 0;
        while (ack == '0 && cyc < 300) begin @(negedge clk); cyc++; end
        check_val("rst_test_ack", ack, 32'd1 << 3);
        req[3] = 1'b0;
        repeat (10) @(negedge clk);
        check_val("rst_test_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        ptr_m = 0; rdata_m = 16'h0000;
        set_rand(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("post_reset_wait", {ack, done, trigger}, 0);
        end
        m_hang = 1'b0; m_release = 1'b1;
        serve_one('0, 40, 1'b0, -1, 1'b0, w);
        check_val("post_reset_gid", w, 0);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_cmd_arbiter.md
# spi_cmd_arbiter

Round-robin arbiter and sequencer that shares one `spi_master` (N slave selects, C-bit frames) among R independent command requesters. It accepts a command word, slave-select vector and SPI mode from each requester and serializes them onto the master's `din`/`target`/`CPOL`/`CPHA`/`trigger` inputs. It returns `dout` to the winning requester, and a watchdog guards against a master that never completes. It sits between the imager's configuration sources and the single `spi_master` instance, replacing the direct `spi_programmer`-to-master connection.

## Interface
- `R`, 4: number of requesters (2..8).
- `N`, 10: slave-select width, matches master `N`.
- `C`, 16: frame width, matches master `C`.
- `TIMEOUT`, 4096: watchdog limit in `CLK_IN` cycles; 16-bit counter.

Ports:
- `CLK_IN` in 1: system clock; all logic on its rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `req` in R: per-requester request level.
- `req_din` in R*C: command words; requester i occupies bits [i*C +: C].
- `req_target` in R*N: slave-select vectors; requester i occupies [i*N +: N].
- `req_cpol`, `req_cpha` in R each: SPI mode per requester.
- `ack` out R: one-cycle grant pulse; command has been captured.
- `done` out R: one-cycle completion pulse.
- `err` out 1: pulses together with `done` when the watchdog expired.
- `rdata` out C: last `dout` captured; valid in the `done` cycle and held afterwards.
- `busy` out 1: high in every state except IDLE.
- `din` out C, `target` out N, `CPOL` out 1, `CPHA` out 1, `trigger` out 1: to `spi_master`.
- `dout` in C, `valid` in 1: from `spi_master`. `valid` is high when the master is idle or finished. It falls after an accepted `trigger` and rises when the frame completes.

## Operation
- **States:** IDLE, SETUP, LAUNCH, WAIT_LOW, WAIT_HIGH.
- **IDLE:**
  - Arbitration happens only when `valid`=1 and `|req`.
  - The winner is the first asserted `req` at or after pointer `ptr`, wrapping modulo R.
  - The winner's `req_din`, `req_target`, `req_cpol` and `req_cpha` are registered onto `din`, `target`, `CPOL` and `CPHA`.
  - The grant index is stored in `gid`.
  - `ptr` becomes `gid+1` mod R.
  - Go to SETUP.
- **SETUP:** `ack[gid]`=1 for this cycle only. This cycle also gives the master one cycle of stable mode before `trigger`. Go to LAUNCH.
- **LAUNCH:** `trigger`=1 for one cycle. Clear the watchdog. Go to WAIT_LOW.
- **WAIT_LOW:** wait for `valid`=0, then go to WAIT_HIGH.
- **WAIT_HIGH:**
  - On `valid`=1: `rdata`<=`dout`, pulse `done[gid]` next cycle, go to IDLE.
- **Watchdog:**
  - Increments every cycle in WAIT_LOW and WAIT_HIGH.
  - On reaching `TIMEOUT`: pulse `done[gid]` and `err`, leave `rdata` unchanged, go to IDLE.
  - IDLE still waits for `valid`=1 before the next grant.
- **Requester rules:**
  - Hold `req` and the payload stable until `ack`.
  - The payload may change from the cycle after `ack`.
  - `req` dropped before `ack` is treated as withdrawn; the request is simply not granted.
  - A requester that re-asserts `req` immediately after `ack` is queued behind the other pending requesters by the pointer rotation.
- **Bus outputs between transfers:** `din`, `target`, `CPOL` and `CPHA` hold their last granted values. `trigger` is only ever high in LAUNCH.

## Timing
- **Reset values:** `ack`=0, `done`=0, `err`=0, `busy`=0, `trigger`=0, `rdata`=0, `din`=0, `target`=0, `CPOL`=0, `CPHA`=0. Also `ptr`=0, state=IDLE, watchdog=0.
- **Request latency:** request sampled in IDLE at edge k → `ack` during cycle k+1 → `trigger` during cycle k+2.
- **Completion latency:** `valid` seen high in WAIT_HIGH at edge m → `done`/`rdata` during cycle m+1. The next grant can be sampled at edge m+1, so the minimum gap between `trigger` pulses is 3 cycles plus the master frame time.
- **Simultaneous events:**
  - All R requests high at once are served in order ptr, ptr+1, ….
  - `valid` rising in the same cycle the watchdog hits `TIMEOUT`: completion wins, `err`=0.
- **Reset mid-transfer:** all state is cleared asynchronously. The in-flight requester gets no `done`. The first grant after reset waits for `valid`=1.
- **Pulse exclusivity:** `ack` and `done` are one-hot-or-zero and are never both high in the same cycle.

## Structure
- **Shared package `spi_arb_pkg`:**
  - state encoding localparams (IDLE=0 … WAIT_HIGH=4);
  - default `TIMEOUT`;
  - width helper for the index (`clog2(R)`).
- **Sub-module `rr_pick`:** combinational rotate-priority encoder that takes `req` and `ptr` and produces `gid` and `any`. The pointer register stays in the parent.

## Test plan
The bench master model drops `valid` 1 cycle after `trigger`, raises it 40 cycles later, and returns `dout`=`din`^16'hFFFF.
- **Single request:** `req[2]` with `din`=16'hA55A, `target`=10'h004 → `ack[2]` at +1, `trigger` at +2, `done[2]` with `rdata`=16'h5AA5, `err`=0.
- **All requesters at once:** all 4 `req` high simultaneously after reset → `ack` order 0,1,2,3 with no double grants. Each requester's `CPOL`/`CPHA` is stable one cycle before its `trigger`.
- **Fairness:** `req[1]` held continuously alongside `req[3]` → grants alternate 1,3,1,3.
- **Watchdog:** master model never raises `valid`, with `TIMEOUT`=100 → `done` and `err` 100 cycles after WAIT_LOW entry, `rdata` unchanged, no new `trigger` until `valid`=1.
- **Reset mid-transfer:** `RST_N` low during WAIT_HIGH → all outputs return to reset values immediately. After release, a pending `req[0]` is granted only once `valid`=1.
- **Boundary/withdrawal:** `valid` and the watchdog limit coincide → `done` with `err`=0. `req` pulsed for one cycle while the arbiter is busy → no `ack`.
